axi_slave_mem: RTL and testbench

- AXI slave endpoint directly downstream of axi_master.
- Terminates all five channels and backs them with an internal byte-strobed memory.
- Write and read paths are independent FSMs and may run concurrently.
- Supports FIXED and INCR bursts; any other burst type, an oversize transfer or an out-of-range address completes with SLVERR.

---
 rtl/axi_pkg.sv | 38 +++
 rtl/axi_slave_mem_array.sv | 24 ++
 rtl/axi_slave_mem.sv | 150 +++++++++++++++
 tb/tb_axi_slave_mem.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: channel widths, burst/response encodings, FSM state types and
// address helpers shared by the AXI slave memory.
package axi_pkg;
   localparam int ADDR_BITS = 32;
   localparam int DATA_BITS = 32;
   localparam int LEN_BITS  = 8;
   localparam int SIZE_BITS = 3;
   localparam int STRB_BITS = DATA_BITS / 8;
   localparam int ADDR_LSB  = $clog2(STRB_BITS);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   typedef struct packed {
      logic [ADDR_BITS-1:0] addr;
      logic [LEN_BITS-1:0]  len;
      logic [SIZE_BITS-1:0] size;
      logic [1:0]           burst;
   } burst_t;

   function automatic logic [ADDR_BITS-1:0] next_addr(input burst_t b);
      return (b.burst == BURST_INCR) ? b.addr + (ADDR_BITS'(1) << b.size) : b.addr;
   endfunction

   // Anything other than FIXED/INCR, a transfer wider than the bus, or a start
   // address past the end of memory is rejected for the whole burst.
   function automatic logic req_error(input burst_t b, input logic [ADDR_BITS-1:0] limit);
      return (b.addr >= limit) || (b.size > SIZE_BITS'(ADDR_LSB)) ||
             (b.burst != BURST_FIXED && b.burst != BURST_INCR);
   endfunction
endpackage

// File: rtl/axi_slave_mem_array.sv
// axi_slave_mem_array: dual-port RAM with a byte-strobed synchronous write port
// and an asynchronous read port (reads see old data until the write edge).
module axi_slave_mem_array #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 32
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic [WIDTH/8-1:0]       i_wstrb,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we)
         for (int b = 0; b < WIDTH / 8; b++)
            if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI slave endpoint backed by a byte-strobed memory; independent
// write (AW/W/B) and read (AR/R) FSMs supporting FIXED and INCR bursts.
module axi_slave_mem
   import axi_pkg::*;
#(
   parameter int MEM_DEPTH = 256
) (
   input  logic                 aclk,
   input  logic                 areset_n,
   input  logic [ADDR_BITS-1:0] aw_addr,
   input  logic [LEN_BITS-1:0]  aw_len,
   input  logic [SIZE_BITS-1:0] aw_size,
   input  logic [1:0]           aw_burst,
   input  logic [3:0]           aw_cache,
   input  logic                 aw_valid,
   output logic                 aw_ready,
   input  logic [DATA_BITS-1:0] w_data,
   input  logic [STRB_BITS-1:0] w_strb,
   input  logic                 w_last,
   input  logic                 w_valid,
   output logic                 w_ready,
   output logic [1:0]           b_resp,
   output logic                 b_valid,
   input  logic                 b_ready,
   input  logic [ADDR_BITS-1:0] ar_addr,
   input  logic [LEN_BITS-1:0]  ar_len,
   input  logic [SIZE_BITS-1:0] ar_size,
   input  logic [1:0]           ar_burst,
   input  logic [3:0]           ar_cache,
   input  logic                 ar_valid,
   output logic                 ar_ready,
   output logic [DATA_BITS-1:0] r_data,
   output logic [1:0]           r_resp,
   output logic                 r_last,
   output logic                 r_valid,
   input  logic                 r_ready
);
   localparam int IDX_BITS = $clog2(MEM_DEPTH);
   localparam logic [ADDR_BITS-1:0] MEM_BYTES = ADDR_BITS'(MEM_DEPTH * STRB_BITS);

   w_state_t             r_w_state;
   burst_t               r_wb;
   logic [LEN_BITS-1:0]  r_w_cnt;
   logic                 r_w_err;
   r_state_t             r_r_state;
   burst_t               r_rb;
   logic [LEN_BITS-1:0]  r_r_cnt;
   logic                 r_r_err;

   burst_t               w_aw_req;
   burst_t               w_ar_req;
   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 w_ar_hs;
   logic                 w_r_hs;
   logic                 w_w_end;
   logic                 w_r_end;
   logic                 w_w_bad;
   logic                 w_r_bad;
   logic                 w_mem_we;
   logic [DATA_BITS-1:0] w_rd_word;
   logic                 w_unused;

   assign w_unused = ^{aw_cache, ar_cache};

   assign w_aw_req = '{addr: aw_addr, len: aw_len, size: aw_size, burst: aw_burst};
   assign w_ar_req = '{addr: ar_addr, len: ar_len, size: ar_size, burst: ar_burst};

   assign aw_ready = r_w_state == W_IDLE;
   assign w_ready  = r_w_state == W_DATA;
   assign b_valid  = r_w_state == W_RESP;
   assign b_resp   = (b_valid && r_w_err) ? RESP_SLVERR : RESP_OKAY;

   assign w_aw_hs  = aw_valid && aw_ready;
   assign w_w_hs   = w_valid && w_ready;
   assign w_w_end  = r_w_cnt == r_wb.len;
   // An INCR burst running off the top of memory errors from that beat onward.
   assign w_w_bad  = r_w_err || (r_wb.addr >= MEM_BYTES);
   assign w_mem_we = w_w_hs && !w_w_bad;

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_w_state <= W_IDLE;
         r_wb      <= '0;
         r_w_cnt   <= '0;
         r_w_err   <= 1'b0;
      end else begin
         case (r_w_state)
            W_IDLE: if (w_aw_hs) begin
               r_wb      <= w_aw_req;
               r_w_cnt   <= '0;
               r_w_err   <= req_error(w_aw_req, MEM_BYTES);
               r_w_state <= W_DATA;
            end
            W_DATA: if (w_w_hs) begin
               r_wb.addr <= next_addr(r_wb);
               r_w_cnt   <= r_w_cnt + LEN_BITS'(1);
               r_w_err   <= w_w_bad || (w_last != w_w_end);
               if (w_w_end) r_w_state <= W_RESP;
            end
            W_RESP: if (b_ready) r_w_state <= W_IDLE;
            default: r_w_state <= W_IDLE;
         endcase
      end
   end

   assign ar_ready = r_r_state == R_IDLE;
   assign r_valid  = r_r_state == R_DATA;
   assign w_ar_hs  = ar_valid && ar_ready;
   assign w_r_hs   = r_valid && r_ready;
   assign w_r_end  = r_r_cnt == r_rb.len;
   assign w_r_bad  = r_r_err || (r_rb.addr >= MEM_BYTES);
   assign r_data   = (r_valid && !w_r_bad) ? w_rd_word : '0;
   assign r_resp   = (r_valid && w_r_bad) ? RESP_SLVERR : RESP_OKAY;
   assign r_last   = r_valid && w_r_end;

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_r_state <= R_IDLE;
         r_rb      <= '0;
         r_r_cnt   <= '0;
         r_r_err   <= 1'b0;
      end else if (r_r_state == R_IDLE) begin
         if (w_ar_hs) begin
            r_rb      <= w_ar_req;
            r_r_cnt   <= '0;
            r_r_err   <= req_error(w_ar_req, MEM_BYTES);
            r_r_state <= R_DATA;
         end
      end else if (w_r_hs) begin
         r_rb.addr <= next_addr(r_rb);
         r_r_cnt   <= r_r_cnt + LEN_BITS'(1);
         r_r_err   <= w_r_bad;
         if (w_r_end) r_r_state <= R_IDLE;
      end
   end

   axi_slave_mem_array #(
      .DEPTH (MEM_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_array (
      .i_clk   (aclk),
      .i_we    (w_mem_we),
      .i_waddr (r_wb.addr[ADDR_LSB +: IDX_BITS]),
      .i_wdata (w_data),
      .i_wstrb (w_strb),
      .i_raddr (r_rb.addr[ADDR_LSB +: IDX_BITS]),
      .o_rdata (w_rd_word)
   );
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed and randomized AXI bursts checked against a
// byte-level memory model that derives per-beat addresses and errors arithmetically.
module tb_axi_slave_mem;
   localparam int LIM = 50;
   localparam logic [31:0] MEM_BYTES = 32'd1024;

   logic        aclk = 1'b0;
   logic        areset_n = 1'b0;
   logic [31:0] aw_addr = '0;
   logic [7:0]  aw_len = '0;
   logic [2:0]  aw_size = '0;
   logic [1:0]  aw_burst = '0;
   logic [3:0]  aw_cache = '0;
   logic        aw_valid = 1'b0;
   logic        aw_ready;
   logic [31:0] w_data = '0;
   logic [3:0]  w_strb = '0;
   logic        w_last = 1'b0;
   logic        w_valid = 1'b0;
   logic        w_ready;
   logic [1:0]  b_resp;
   logic        b_valid;
   logic        b_ready = 1'b0;
   logic [31:0] ar_addr = '0;
   logic [7:0]  ar_len = '0;
   logic [2:0]  ar_size = '0;
   logic [1:0]  ar_burst = '0;
   logic [3:0]  ar_cache = '0;
   logic        ar_valid = 1'b0;
   logic        ar_ready;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;
   logic        r_valid;
   logic        r_ready = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_mem   [256];
   logic [31:0] tx_data [256];
   logic [3:0]  tx_strb [256];

   always #5 aclk = ~aclk;

   axi_slave_mem dut (
      .aclk(aclk), .areset_n(areset_n),
      .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
      .aw_cache(aw_cache), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
      .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .ar_cache(ar_cache), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                             input logic [2:0] sz, input logic [1:0] bu);
      return (bu == 2'b01) ? a + 32'(i) * (32'd1 << sz) : a;
   endfunction

   // Applies the first nb beats of tx_* to the model; returns 1 if the burst earns SLVERR.
   function automatic bit model_write(input logic [31:0] a, input int len, input logic [2:0] sz,
                                      input logic [1:0] bu, input bit bad_last, input int nb);
      bit err = bad_last || sz > 3'd2 || bu > 2'b01;
      for (int i = 0; i < nb; i++) begin
         logic [31:0] ai = beat_addr(a, i, sz, bu);
         if (ai >= MEM_BYTES) err = 1'b1;
         if (!err)
            for (int k = 0; k < 4; k++)
               if (tx_strb[i][k]) m_mem[ai[9:2]][8*k +: 8] = tx_data[i][8*k +: 8];
      end
      return err || len < 0;
   endfunction

   task automatic fill_tx(input int len, input bit full_strb);
      for (int i = 0; i <= len; i++) begin
         tx_data[i] = $urandom;
         tx_strb[i] = full_strb ? 4'hF : 4'($urandom);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input int len, input logic [2:0] sz,
                           input logic [1:0] bu, input bit bad_last, input int bstall);
      logic [1:0] eresp;
      int n;
      eresp = model_write(a, len, sz, bu, bad_last, len + 1) ? 2'b10 : 2'b00;
      @(negedge aclk);
      aw_addr = a; aw_len = 8'(len); aw_size = sz; aw_burst = bu;
      aw_cache = 4'($urandom); aw_valid = 1'b1;
      n = 0;
      while (!aw_ready && n < LIM) begin @(negedge aclk); n++; end
      check("aw_wait", 32'(n >= LIM), 0);
      @(negedge aclk);
      aw_valid = 1'b0;
      check("aw_drop", aw_ready, 0);
      for (int i = 0; i <= len; i++) begin
         w_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge aclk);
         w_data = tx_data[i]; w_strb = tx_strb[i];
         w_last = (i == len) ^ (bad_last && i == 0);
         w_valid = 1'b1;
         n = 0;
         while (!w_ready && n < LIM) begin @(negedge aclk); n++; end
         check("w_wait", 32'(n >= LIM), 0);
         @(negedge aclk);
      end
      w_valid = 1'b0;
      check("b_lat", b_valid, 1);
      for (int i = 0; i < bstall; i++) begin
         check("b_hold", b_valid, 1);
         check("aw_block", aw_ready, 0);
         @(negedge aclk);
      end
      check("b_resp", b_resp, eresp);
      b_ready = 1'b1;
      @(negedge aclk);
      b_ready = 1'b0;
      check("b_done", {30'd0, b_valid, aw_ready}, 1);
   endtask

   task automatic do_read(input logic [31:0] a, input int len, input logic [2:0] sz,
                          input logic [1:0] bu, input int stall_beat, input int stall_n);
      logic [31:0] ed [$];
      logic [1:0]  er [$];
      bit err;
      int n, st;
      err = sz > 3'd2 || bu > 2'b01;
      for (int i = 0; i <= len; i++) begin
         logic [31:0] ai = beat_addr(a, i, sz, bu);
         if (ai >= MEM_BYTES) err = 1'b1;
         ed.push_back(err ? 32'd0 : m_mem[ai[9:2]]);
         er.push_back(err ? 2'b10 : 2'b00);
      end
      @(negedge aclk);
      ar_addr = a; ar_len = 8'(len); ar_size = sz; ar_burst = bu;
      ar_cache = 4'($urandom); ar_valid = 1'b1;
      n = 0;
      while (!ar_ready && n < LIM) begin @(negedge aclk); n++; end
      check("ar_wait", 32'(n >= LIM), 0);
      @(negedge aclk);
      ar_valid = 1'b0;
      check("r_lat", r_valid, 1);
      for (int i = 0; i <= len; i++) begin
         n = 0;
         while (!r_valid && n < LIM) begin @(negedge aclk); n++; end
         check("r_wait", 32'(n >= LIM), 0);
         check("r_data", r_data, ed[i]);
         check("r_resp", r_resp, er[i]);
         check("r_last", r_last, i == len);
         st = (i == stall_beat) ? stall_n : (stall_beat < 0 ? int'($urandom_range(0, 1)) : 0);
         repeat (st) begin
            @(negedge aclk);
            check("r_hold_valid", r_valid, 1);
            check("r_hold_data", r_data, ed[i]);
            check("r_hold_last", r_last, i == len);
         end
         r_ready = 1'b1;
         @(negedge aclk);
         r_ready = 1'b0;
      end
      check("r_done", {30'd0, r_valid, ar_ready}, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge aclk);
      check("rst_aw_ready", aw_ready, 1);
      check("rst_ar_ready", ar_ready, 1);
      check("rst_w_ready", w_ready, 0);
      check("rst_b_valid", b_valid, 0);
      check("rst_r_valid", r_valid, 0);
      check("rst_r_last", r_last, 0);
      check("rst_resps", {28'd0, b_resp, r_resp}, 0);
      check("rst_r_data", r_data, 0);
      areset_n = 1'b1;

      // Whole memory gets known contents so the model is exact everywhere.
      fill_tx(255, 1'b1);
      do_write(32'h0, 255, 3'd2, 2'b01, 1'b0, 0);
      do_read(32'h3C0, 15, 3'd2, 2'b01, -1, 0);

      for (int i = 0; i < 4; i++) begin tx_data[i] = 32'hA0 + 32'(i); tx_strb[i] = 4'hF; end
      do_write(32'h10, 3, 3'd2, 2'b01, 1'b0, 0);
      do_read(32'h10, 3, 3'd2, 2'b01, -1, 0);

      tx_data[0] = 32'h11; tx_data[1] = 32'h22; tx_data[2] = 32'h33;
      for (int i = 0; i < 3; i++) tx_strb[i] = 4'hF;
      do_write(32'h20, 2, 3'd2, 2'b00, 1'b0, 0);
      do_read(32'h20, 0, 3'd2, 2'b00, -1, 0);

      tx_data[0] = 32'hFFFF_FFFF; tx_strb[0] = 4'hF;
      do_write(32'h40, 0, 3'd2, 2'b01, 1'b0, 0);
      tx_data[0] = 32'h1234_5678; tx_strb[0] = 4'h5;
      do_write(32'h40, 0, 3'd2, 2'b01, 1'b0, 0);
      do_read(32'h40, 0, 3'd2, 2'b01, -1, 0);

      fill_tx(0, 1'b1);
      do_write(MEM_BYTES, 0, 3'd2, 2'b01, 1'b0, 0);
      do_read(32'h0, 0, 3'd2, 2'b01, -1, 0);
      do_read(32'h10, 3, 3'd2, 2'b10, -1, 0);
      fill_tx(1, 1'b1);
      do_write(32'h80, 1, 3'd3, 2'b01, 1'b0, 0);
      fill_tx(1, 1'b1);
      do_write(32'h90, 1, 3'd2, 2'b10, 1'b0, 0);
      do_read(32'h80, 3, 3'd2, 2'b01, -1, 0);

      fill_tx(3, 1'b1);
      do_write(32'h3F8, 3, 3'd2, 2'b01, 1'b0, 0);
      do_read(32'h3F8, 3, 3'd2, 2'b01, -1, 0);

      fill_tx(2, 1'b1);
      for (int i = 0; i < 3; i++) tx_strb[i] = 4'h0;
      do_write(32'h60, 2, 3'd2, 2'b01, 1'b1, 0);
      do_write(32'h70, 0, 3'd2, 2'b01, 1'b1, 0);

      do_read(32'h100, 3, 3'd2, 2'b01, 1, 5);
      fill_tx(1, 1'b1);
      do_write(32'h104, 1, 3'd2, 2'b01, 1'b0, 3);

      fill_tx(7, 1'b0);
      fork
         do_write(32'h200, 7, 3'd2, 2'b01, 1'b0, 1);
         do_read(32'h000, 7, 3'd2, 2'b01, -1, 0);
      join
      do_read(32'h200, 7, 3'd2, 2'b01, -1, 0);

      // Abandon a write burst part-way through: only beat 0 reaches memory.
      fill_tx(3, 1'b1);
      void'(model_write(32'h180, 3, 3'd2, 2'b01, 1'b0, 1));
      @(negedge aclk);
      aw_addr = 32'h180; aw_len = 8'd3; aw_size = 3'd2; aw_burst = 2'b01; aw_valid = 1'b1;
      @(negedge aclk);
      aw_valid = 1'b0;
      w_data = tx_data[0]; w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
      @(negedge aclk);
      w_data = tx_data[1];
      #2 areset_n = 1'b0;
      #1;
      check("arst_aw_ready", aw_ready, 1);
      check("arst_ar_ready", ar_ready, 1);
      check("arst_w_ready", w_ready, 0);
      check("arst_b_valid", b_valid, 0);
      check("arst_r_valid", r_valid, 0);
      check("arst_r_last", r_last, 0);
      check("arst_resps", {28'd0, b_resp, r_resp}, 0);
      check("arst_r_data", r_data, 0);
      w_valid = 1'b0;
      repeat (2) @(negedge aclk);
      areset_n = 1'b1;
      fill_tx(0, 1'b1);
      do_write(32'h1C0, 0, 3'd2, 2'b01, 1'b0, 0);
      do_read(32'h180, 3, 3'd2, 2'b01, -1, 0);
      do_read(32'h1C0, 0, 3'd2, 2'b01, -1, 0);

      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         logic [2:0]  sz;
         logic [1:0]  bu;
         int          len;
         a   = 32'($urandom_range(0, 1100));
         sz  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         bu  = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
         len = int'($urandom_range(0, 7));
         fill_tx(len, $urandom_range(0, 1) == 1);
         do_write(a, len, sz, bu, 1'b0, int'($urandom_range(0, 2)));
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1023));
         do_read(a, len, sz, bu, -1, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
